// File: rtl/uart_cmd_ctrl_if.sv
// Command/read-return bus between the UART command controller and the
// memory/TFT side.
//   master : controller side (drives cmd_valid/cmd_write/cmd_addr/cmd_wdata)
//   slave  : downstream side (drives cmd_ready and the rd_data/rd_valid return)
interface uart_cmd_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic [15:0] rd_data;
  logic        rd_valid;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rd_data, rd_valid
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses byte frames from a UART receiver
//   55 CMD ADDR_H ADDR_L [DATA_H DATA_L] [CKS]   (CMD 57 = write, 52 = read)
// into memory/TFT commands, and returns read data as two transmitted bytes
// (high byte first).
//
// Optional feature: define UART_CMD_CKSUM_EN to require a trailing CKS byte,
// the XOR of CMD through the last address/data byte. Without it, the command
// is issued directly after the last address/data byte.
//
// Ports:
//   sys_clk, sys_nrst  clock and synchronous active-low reset
//   rx_data, rx_valid  received byte and its one-cycle strobe
//   cmd                command bus (master modport): request/ready handshake
//                      plus read-return data
//   tx_data, tx_start  byte and one-cycle strobe to the UART transmitter
//   tx_busy            transmitter busy
//   frame_err          one-cycle pulse on bad CMD, bad CKS or inter-byte timeout
//
// Parameter TIMEOUT: inter-byte timeout in sys_clk cycles (16-bit counter).
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic            sys_clk,
  input  logic            sys_nrst,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  uart_cmd_ctrl_if.master cmd,
  output logic [7:0]      tx_data,
  output logic            tx_start,
  input  logic            tx_busy,
  output logic            frame_err
);

  localparam logic [7:0]  SOF_CODE = 8'h55;
  localparam logic [7:0]  WR_CODE  = 8'h57;
  localparam logic [7:0]  RD_CODE  = 8'h52;
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, CMD, AH, AL, DH, DL, ISSUE, WAIT_RD, TXH, TXL
`ifdef UART_CMD_CKSUM_EN
    , CKS
`endif
  } state_t;

  // State entered after the last address/data byte.
`ifdef UART_CMD_CKSUM_EN
  localparam state_t END_ST = CKS;
`else
  localparam state_t END_ST = ISSUE;
`endif

  state_t      state, state_d;
  logic        cmd_valid_q, cmd_write_q;
  logic [15:0] addr_q, wdata_q, rd_q, to_cnt;
  logic [1:0]  tx_step, tx_step_d;
  logic        start_d, err_d, in_parse, timeout_hit;

`ifdef UART_CMD_CKSUM_EN
  logic [7:0]  cks;
  assign in_parse = state inside {CMD, AH, AL, DH, DL, CKS};
`else
  assign in_parse = state inside {CMD, AH, AL, DH, DL};
`endif

  assign timeout_hit = in_parse && !rx_valid && (to_cnt == TO_LAST);

  assign cmd.cmd_valid = cmd_valid_q;
  assign cmd.cmd_write = cmd_write_q;
  assign cmd.cmd_addr  = addr_q;
  assign cmd.cmd_wdata = wdata_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) state <= IDLE;
    else           state <= state_d;
  end

  // tx_step in TXH/TXL: 0 = wait for !tx_busy, 1 = strobe cycle,
  // 2 = settle cycle where tx_busy is not trusted yet.
  always_comb begin
    state_d   = state;
    err_d     = 1'b0;
    start_d   = 1'b0;
    tx_step_d = tx_step;
    case (state)
      IDLE: if (rx_valid && rx_data == SOF_CODE) state_d = CMD;
      CMD: begin
        if (rx_valid) begin
          if (rx_data == WR_CODE || rx_data == RD_CODE) begin
            state_d = AH;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      AH: if (rx_valid) state_d = AL;
      AL: if (rx_valid) state_d = cmd_write_q ? DH : END_ST;
      DH: if (rx_valid) state_d = DL;
      DL: if (rx_valid) state_d = END_ST;
`ifdef UART_CMD_CKSUM_EN
      CKS: begin
        if (rx_valid) begin
          if (rx_data == cks) begin
            state_d = ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      ISSUE:   if (cmd.cmd_ready) state_d = cmd_write_q ? IDLE : WAIT_RD;
      WAIT_RD: if (cmd.rd_valid) state_d = TXH;
      TXH, TXL: begin
        case (tx_step)
          2'd0: begin
            if (!tx_busy) begin
              start_d   = 1'b1;
              tx_step_d = 2'd1;
            end
          end
          2'd1: tx_step_d = 2'd2;
          default: begin
            tx_step_d = 2'd0;
            state_d   = (state == TXH) ? TXL : IDLE;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
    if (timeout_hit) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      frame_err   <= 1'b0;
      to_cnt      <= '0;
      tx_step     <= 2'd0;
    end else begin
      // cmd_valid is high exactly while the FSM sits in ISSUE.
      cmd_valid_q <= (state_d == ISSUE);
      tx_start    <= start_d;
      frame_err   <= err_d;
      tx_step     <= tx_step_d;
      if (!in_parse || rx_valid || timeout_hit) to_cnt <= '0;
      else                                      to_cnt <= to_cnt + 16'd1;
      if (start_d) tx_data <= (state == TXH) ? rd_q[15:8] : rd_q[7:0];
      if (rx_valid) begin
        case (state)
          CMD: begin
            cmd_write_q <= (rx_data == WR_CODE);
            wdata_q     <= '0;
          end
          AH:      addr_q[15:8]  <= rx_data;
          AL:      addr_q[7:0]   <= rx_data;
          DH:      wdata_q[15:8] <= rx_data;
          DL:      wdata_q[7:0]  <= rx_data;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (state == WAIT_RD && cmd.rd_valid) rd_q <= cmd.rd_data;
  end

`ifdef UART_CMD_CKSUM_EN
  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      cks <= '0;
    end else if (rx_valid) begin
      if (state == CMD)                        cks <= rx_data;
      else if (state inside {AH, AL, DH, DL})  cks <= cks ^ rx_data;
    end
  end
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;
  localparam int unsigned TIMEOUT = 50000;
`ifdef UART_CMD_CKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          cyc;
    int          hold;
  } cmd_t;

  logic       sys_clk = 1'b0;
  logic       sys_nrst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       frame_err;

  uart_cmd_ctrl_if bus ();

  uart_cmd_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .sys_clk   (sys_clk),
    .sys_nrst  (sys_nrst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cmd       (bus),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .frame_err (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  cmd_t        exp_cmd[$];
  logic [7:0]  exp_tx[$];
  int          exp_err[$];
  logic [15:0] rd_vals[$];
  int          rd_pending = 0;
  int          rd_gap     = 0;
  int          ready_delay = 0;
  int          busy_len    = 20;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Reference model: decide from the frame bytes alone whether it yields a
  // command or a frame error, and at which byte the decision falls.
  function automatic void classify(input bq_t f, output int kind, output int idx);
    int last;
    logic [7:0] x;
    kind = 0;
    idx  = 0;
    if (f[1] != 8'h57 && f[1] != 8'h52) begin
      kind = 1;
      idx  = 1;
      return;
    end
    last = (f[1] == 8'h57) ? 5 : 3;
    if (CKS_EN) begin
      x = 8'h00;
      for (int i = 1; i <= last; i++) x = x ^ f[i];
      idx = last + 1;
      if (f[idx] != x) kind = 1;
    end else begin
      idx = last;
    end
  endfunction

  task automatic lit(input logic [55:0] bytes, input int n, output bq_t f);
    f.delete();
    for (int i = 0; i < n; i++) f.push_back(bytes[8*(n-1-i) +: 8]);
    if (!CKS_EN && n > 3) void'(f.pop_back());
  endtask

  task automatic mk_frame(input logic [7:0] c, input logic [15:0] a, input logic [15:0] d,
                          input logic [7:0] flip, output bq_t f);
    logic [7:0] x;
    f.delete();
    f.push_back(8'h55);
    f.push_back(c);
    if (c == 8'h57 || c == 8'h52) begin
      f.push_back(a[15:8]);
      f.push_back(a[7:0]);
      if (c == 8'h57) begin
        f.push_back(d[15:8]);
        f.push_back(d[7:0]);
      end
      if (CKS_EN) begin
        x = 8'h00;
        for (int i = 1; i < f.size(); i++) x = x ^ f[i];
        f.push_back(x ^ flip);
      end
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) step();
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bq_t f, input int gap_max, input logic [15:0] rdv);
    int kind, idx;
    cmd_t e;
    classify(f, kind, idx);
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i], (i == 0) ? 0 : int'($urandom_range(gap_max, 0)));
      if (i == idx) begin
        if (kind == 1) begin
          exp_err.push_back(cyc);
        end else begin
          e.wr    = (f[1] == 8'h57);
          e.addr  = {f[2], f[3]};
          e.wdata = e.wr ? {f[4], f[5]} : 16'h0000;
          e.cyc   = cyc;
          e.hold  = ready_delay + 1;
          exp_cmd.push_back(e);
          if (!e.wr) begin
            rd_vals.push_back(rdv);
            exp_tx.push_back(rdv[15:8]);
            exp_tx.push_back(rdv[7:0]);
          end
        end
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((exp_cmd.size() != 0 || exp_tx.size() != 0 || exp_err.size() != 0 || rd_pending != 0)
           && n < bound) begin
      step();
      n++;
    end
    total++;
    if (n >= bound) begin
      bad++;
      $display("FAIL wait_idle: expectations still pending after %0d cycles (cmd=%0d tx=%0d err=%0d)",
               n, exp_cmd.size(), exp_tx.size(), exp_err.size());
    end
    repeat (3) step();
  endtask

  task automatic check_reset_outputs();
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_cmd_write", bus.cmd_write, 0);
    chk("rst_cmd_addr",  bus.cmd_addr,  0);
    chk("rst_cmd_wdata", bus.cmd_wdata, 0);
    chk("rst_tx_data",   tx_data,       0);
    chk("rst_tx_start",  tx_start,      0);
    chk("rst_frame_err", frame_err,     0);
  endtask

  // Downstream ready: held low for ready_delay cycles after each request.
  int rdy_cnt = -1;
  initial begin
    bus.cmd_ready = 1'b0;
    forever begin
      step();
      if (!bus.cmd_valid)  rdy_cnt = -1;
      else if (rdy_cnt < 0) rdy_cnt = ready_delay;
      else if (rdy_cnt > 0) rdy_cnt--;
      bus.cmd_ready = bus.cmd_valid && (rdy_cnt == 0);
    end
  end

  // Read-return responder, with occasional stray rd_valid while no read is open.
  initial begin
    bus.rd_valid = 1'b0;
    bus.rd_data  = 16'h0000;
    forever begin
      step();
      bus.rd_valid = 1'b0;
      if (rd_pending > 0) begin
        if (rd_gap > 0) begin
          rd_gap--;
        end else if (rd_vals.size() > 0) begin
          bus.rd_data  = rd_vals.pop_front();
          bus.rd_valid = 1'b1;
          rd_pending--;
        end
      end else if ($urandom_range(15, 0) == 0) begin
        bus.rd_data  = 16'($urandom);
        bus.rd_valid = 1'b1;
      end
    end
  end

  // Transmitter: busy for busy_len cycles after taking a strobe.
  initial begin
    logic s;
    int   bcnt;
    bcnt    = 0;
    tx_busy = 1'b0;
    forever begin
      @(negedge sys_clk);
      s = tx_start;
      step();
      if (s)             bcnt = busy_len;
      else if (bcnt > 0) bcnt--;
      tx_busy = (bcnt > 0);
    end
  end

  // Monitor / scoreboard.
  logic        pv = 1'b0, pacc = 1'b0, pbusy = 1'b0, ptx = 1'b0, pw = 1'b0;
  logic [15:0] pa = '0, pd = '0;
  int          hold_cnt = 0;
  always @(negedge sys_clk) begin
    cmd_t e;
    if (!sys_nrst) begin
      pv = 1'b0; pacc = 1'b0; pbusy = 1'b0; ptx = 1'b0;
    end else begin
      if (pacc) chk("valid_after_accept", bus.cmd_valid, 0);
      pacc = 1'b0;
      if (bus.cmd_valid) begin
        if (!pv) begin
          hold_cnt = 0;
          if (exp_cmd.size() == 0) unexp("cmd_valid", bus.cmd_addr);
          else                     chk("cmd_rise_cycle", cyc, exp_cmd[0].cyc);
        end else begin
          chk("hold_write", bus.cmd_write, pw);
          chk("hold_addr",  bus.cmd_addr,  pa);
          chk("hold_wdata", bus.cmd_wdata, pd);
        end
        hold_cnt++;
        if (bus.cmd_ready) begin
          pacc = 1'b1;
          if (exp_cmd.size() > 0) begin
            e = exp_cmd.pop_front();
            chk("cmd_write", bus.cmd_write, e.wr);
            chk("cmd_addr",  bus.cmd_addr,  e.addr);
            chk("cmd_wdata", bus.cmd_wdata, e.wdata);
            chk("cmd_hold_cycles", hold_cnt, e.hold);
            if (!e.wr) begin
              rd_gap = $urandom_range(4, 0);
              rd_pending++;
            end
          end
        end
      end
      if (tx_start) begin
        chk("tx_start_while_busy", pbusy, 0);
        chk("tx_start_width", ptx, 0);
        if (exp_tx.size() == 0) unexp("tx_start", tx_data);
        else                    chk("tx_data", tx_data, exp_tx.pop_front());
      end
      if (frame_err) begin
        if (exp_err.size() == 0) unexp("frame_err", cyc);
        else                     chk("frame_err_cycle", cyc, exp_err.pop_front());
      end
      pv    = bus.cmd_valid;
      pw    = bus.cmd_write;
      pa    = bus.cmd_addr;
      pd    = bus.cmd_wdata;
      pbusy = tx_busy;
      ptx   = tx_start;
    end
  end

  initial begin
    bq_t        f;
    int         kind;
    logic [7:0] c, junk;
    sys_nrst = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) step();
    check_reset_outputs();
    sys_nrst = 1'b1;
    repeat (2) step();

    // Reference write frame.
    lit(56'h55_57_12_34_AB_CD_17, 7, f);
    send_frame(f, 0, 16'h0000);
    wait_idle(500);

    // Reference read frame; bytes arriving during the read are dropped.
    busy_len = 20;
    lit(56'h55_52_00_10_42, 5, f);
    send_frame(f, 0, 16'hBEEF);
    send_byte(8'h55, 0);
    send_byte(8'h57, 0);
    wait_idle(500);

    // Bad checksum, then a good frame.
    if (CKS_EN) begin
      lit(56'h55_57_12_34_AB_CD_18, 7, f);
      send_frame(f, 0, 16'h0000);
      wait_idle(500);
      lit(56'h55_57_12_34_AB_CD_17, 7, f);
      send_frame(f, 0, 16'h0000);
      wait_idle(500);
    end

    // Unknown command byte.
    lit(56'h55_41, 2, f);
    send_frame(f, 0, 16'h0000);
    wait_idle(500);

    // Stalled handshake: ready low 10 cycles, bytes during the stall dropped.
    ready_delay = 10;
    mk_frame(8'h57, 16'h2468, 16'h1357, 8'h00, f);
    send_frame(f, 1, 16'h0000);
    send_byte(8'h55, 0);
    send_byte(8'h57, 0);
    send_byte(8'h12, 0);
    wait_idle(500);
    ready_delay = 0;

    // Reset mid-frame.
    send_byte(8'h55, 0);
    send_byte(8'h57, 0);
    send_byte(8'h12, 0);
    sys_nrst = 1'b0;
    step();
    check_reset_outputs();
    sys_nrst = 1'b1;
    mk_frame(8'h57, 16'hA5A5, 16'h0F0F, 8'h00, f);
    send_frame(f, 0, 16'h0000);
    wait_idle(500);

    // Randomized frames.
    for (int k = 0; k < 24; k++) begin
      kind = $urandom_range(3, 0);
      if (!CKS_EN && kind == 2) kind = 0;
      ready_delay = $urandom_range(3, 0);
      busy_len    = $urandom_range(20, 0);
      if ($urandom_range(1, 0) == 1) begin
        junk = 8'($urandom);
        if (junk == 8'h55) junk = 8'h00;
        send_byte(junk, $urandom_range(2, 0));
      end
      case (kind)
        0: mk_frame(8'h57, 16'($urandom), 16'($urandom), 8'h00, f);
        1: mk_frame(8'h52, 16'($urandom), 16'h0000, 8'h00, f);
        2: mk_frame(($urandom_range(1, 0) == 1) ? 8'h57 : 8'h52, 16'($urandom), 16'($urandom),
                    8'($urandom_range(255, 1)), f);
        default: begin
          c = 8'($urandom);
          if (c == 8'h57 || c == 8'h52) c = 8'h00;
          mk_frame(c, 16'h0000, 16'h0000, 8'h00, f);
        end
      endcase
      send_frame(f, 3, 16'($urandom));
      wait_idle(3000);
    end

    // Inter-byte timeout after 55 57.
    send_byte(8'h55, 0);
    send_byte(8'h57, 0);
    exp_err.push_back(cyc + int'(TIMEOUT));
    wait_idle(int'(TIMEOUT) + 200);

    chk("leftover_cmd", exp_cmd.size(), 0);
    chk("leftover_tx",  exp_tx.size(),  0);
    chk("leftover_err", exp_err.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
